ula_multiciclo: RTL and testbench

//  Parametrised sequential ALU for the MIPS datapath; successor to the combinational 32-bit ALU.

---
 rtl/ula_multiciclo_if.sv | 31 +++
 rtl/ula_multiciclo.sv | 218 +++++++++++++++++++++
 tb/tb_ula_multiciclo.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/ula_multiciclo_if.sv
// Request/response bundle between the datapath control and the sequential ALU.
// The master drives start/op/a/b; the ALU answers with busy, a done pulse and the registered results.
interface ula_multiciclo_if #(
    parameter int WIDTH = 32
);
    // Handshake: a request is taken on a rising edge where start=1 and busy=0. a/b/op are
    // sampled only on that edge. done pulses for one cycle when the results become valid,
    // and the results then hold until the next done.
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] saida;
    logic [WIDTH-1:0] saida_hi;
    logic             zero;
    logic             overflow;
    logic             div_zero;
    logic             illegal;

    modport master (
        output start, op, a, b,
        input  busy, done, saida, saida_hi, zero, overflow, div_zero, illegal
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, saida, saida_hi, zero, overflow, div_zero, illegal
    );
endinterface

// File: rtl/ula_multiciclo.sv
// Sequential WIDTH-bit ALU with a start/done handshake. Define ULA_MULDIV_EN to build the
// iterative MULU (shift-add) and DIVU (restoring) paths; without it those opcodes are illegal.
module ula_multiciclo #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ula_multiciclo_if.slave      bus,
    output logic [1:0]           state_dbg
);
    localparam int SHAMT_W = $clog2(WIDTH);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_NOR  = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t           state;
    logic             done_q;
    logic [WIDTH-1:0] saida_q;
    logic             zero_q;
    logic             ov_q;
    logic             dz_q;
    logic             ill_q;

    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   dif;
    logic [SHAMT_W-1:0] sh;
    logic [WIDTH-1:0]   comb_res;
    logic               comb_ov;
    logic               comb_ill;

    always_comb begin
        sum      = bus.a + bus.b;
        dif      = bus.a - bus.b;
        sh       = bus.b[SHAMT_W-1:0];
        comb_res = '0;
        comb_ov  = 1'b0;
        comb_ill = 1'b0;
        case (bus.op)
            OP_AND:  comb_res = bus.a & bus.b;
            OP_OR:   comb_res = bus.a | bus.b;
            OP_ADD: begin
                comb_res = sum;
                comb_ov  = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                comb_res = dif;
                comb_ov  = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (dif[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_NOR:  comb_res = ~(bus.a | bus.b);
            OP_XOR:  comb_res = bus.a ^ bus.b;
            OP_SLTU: comb_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            // Direct signed compare, so the result stays right when a-b would overflow.
            OP_SLT:  comb_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_SLL:  comb_res = bus.a << sh;
            OP_SRL:  comb_res = bus.a >> sh;
            OP_SRA:  comb_res = $signed(bus.a) >>> sh;
            default: comb_ill = 1'b1;
        endcase
    end

`ifdef ULA_MULDIV_EN
    localparam logic [3:0] OP_MULU = 4'b1100;
    localparam logic [3:0] OP_DIVU = 4'b1101;
    localparam int         CNT_W   = $clog2(WIDTH) + 1;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] operand;   // multiplicand or divisor, frozen for the whole operation
    logic [WIDTH-1:0] acc_hi;    // partial product high half / running remainder
    logic [WIDTH-1:0] acc_lo;    // multiplier being shifted out / quotient being shifted in
    logic [WIDTH-1:0] saida_hi_q;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_n;
    logic [WIDTH-1:0] mul_lo_n;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [WIDTH-1:0] div_hi_n;
    logic [WIDTH-1:0] div_lo_n;

    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
        mul_hi_n  = mul_sum[WIDTH:1];
        mul_lo_n  = {mul_sum[0], acc_lo[WIDTH-1:1]};
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, operand};
        if (!div_diff[WIDTH]) begin
            div_hi_n = div_diff[WIDTH-1:0];
            div_lo_n = {acc_lo[WIDTH-2:0], 1'b1};
        end else begin
            div_hi_n = div_shift[WIDTH-1:0];
            div_lo_n = {acc_lo[WIDTH-2:0], 1'b0};
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            done_q  <= 1'b0;
            saida_q <= '0;
            zero_q  <= 1'b1;
            ov_q    <= 1'b0;
            dz_q    <= 1'b0;
            ill_q   <= 1'b0;
`ifdef ULA_MULDIV_EN
            cnt        <= '0;
            operand    <= '0;
            acc_hi     <= '0;
            acc_lo     <= '0;
            saida_hi_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
`ifdef ULA_MULDIV_EN
                    if (bus.op == OP_MULU) begin
                        state   <= MUL;
                        cnt     <= CNT_W'(WIDTH);
                        operand <= bus.a;
                        acc_hi  <= '0;
                        acc_lo  <= bus.b;
                    end else if (bus.op == OP_DIVU && bus.b != '0) begin
                        state   <= DIV;
                        cnt     <= CNT_W'(WIDTH);
                        operand <= bus.b;
                        acc_hi  <= '0;
                        acc_lo  <= bus.a;
                    end else if (bus.op == OP_DIVU) begin
                        saida_q    <= '1;
                        saida_hi_q <= bus.a;
                        zero_q     <= 1'b0;
                        ov_q       <= 1'b0;
                        dz_q       <= 1'b1;
                        ill_q      <= 1'b0;
                        done_q     <= 1'b1;
                    end else
`endif
                    begin
                        saida_q <= comb_res;
`ifdef ULA_MULDIV_EN
                        saida_hi_q <= '0;
`endif
                        zero_q  <= (comb_res == '0);
                        ov_q    <= comb_ov;
                        dz_q    <= 1'b0;
                        ill_q   <= comb_ill;
                        done_q  <= 1'b1;
                    end
                end
`ifdef ULA_MULDIV_EN
                MUL: begin
                    acc_hi <= mul_hi_n;
                    acc_lo <= mul_lo_n;
                    cnt    <= cnt - 1'b1;
                    // Last iteration publishes the freshly computed step, not the stale accumulator.
                    if (cnt == CNT_W'(1)) begin
                        state      <= IDLE;
                        saida_q    <= mul_lo_n;
                        saida_hi_q <= mul_hi_n;
                        zero_q     <= (mul_lo_n == '0);
                        ov_q       <= 1'b0;
                        dz_q       <= 1'b0;
                        ill_q      <= 1'b0;
                        done_q     <= 1'b1;
                    end
                end
                DIV: begin
                    acc_hi <= div_hi_n;
                    acc_lo <= div_lo_n;
                    cnt    <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state      <= IDLE;
                        saida_q    <= div_lo_n;
                        saida_hi_q <= div_hi_n;
                        zero_q     <= (div_lo_n == '0);
                        ov_q       <= 1'b0;
                        dz_q       <= 1'b0;
                        ill_q      <= 1'b0;
                        done_q     <= 1'b1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ULA_MULDIV_EN
    assign bus.busy     = (state != IDLE);
    assign bus.saida_hi = saida_hi_q;
`else
    assign bus.busy     = 1'b0;
    assign bus.saida_hi = '0;
`endif
    assign bus.done     = done_q;
    assign bus.saida    = saida_q;
    assign bus.zero     = zero_q;
    assign bus.overflow = ov_q;
    assign bus.div_zero = dz_q;
    assign bus.illegal  = ill_q;
    assign state_dbg    = state;
endmodule

// File: tb/tb_ula_multiciclo.sv
// Randomised scoreboard bench for ula_multiciclo (WIDTH=32), covering both builds of ULA_MULDIV_EN.
module tb_ula_multiciclo;
  localparam int W     = 32;
  localparam int EXP_W = 2 * W + 4;
`ifdef ULA_MULDIV_EN
  localparam bit MULDIV_EN = 1'b1;
`else
  localparam bit MULDIV_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ula_multiciclo_if #(.WIDTH(W)) bus ();
  logic [1:0] state_dbg;

  ula_multiciclo #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .state_dbg(state_dbg)
  );

  int checks = 0;
  int errors = 0;
  logic [EXP_W-1:0] exp_q[$];
  int unsigned      lat_q[$];
  logic [EXP_W-1:0] mon_act;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // reference model: returns {saida_hi, saida, zero, overflow, div_zero, illegal}
  function automatic logic [EXP_W-1:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b, output int lat);
    logic [W-1:0] r, hi;
    logic ov, dz, ill;
    longint sa, sb, s;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0; hi = '0; ov = 0; dz = 0; ill = 0; lat = 0; s = 0; p = '0;
    case (op)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: begin s = sa + sb; r = s[31:0]; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd3: begin s = sa - sb; r = s[31:0]; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd4: r = ~(a | b);
      4'd5: r = a ^ b;
      4'd6: r = (a < b) ? 32'd1 : 32'd0;
      4'd7: r = (sa < sb) ? 32'd1 : 32'd0;
      4'd8: r = a << b[4:0];
      4'd9: r = a >> b[4:0];
      4'd10: begin s = sa >>> b[4:0]; r = s[31:0]; end
      4'd12: if (MULDIV_EN) begin
        p = {32'd0, a} * {32'd0, b};
        r = p[31:0]; hi = p[63:32]; lat = W;
      end else ill = 1;
      4'd13: if (MULDIV_EN) begin
        if (b == 0) begin r = '1; hi = a; dz = 1; end
        else begin r = a / b; hi = a % b; lat = W; end
      end else ill = 1;
      default: ill = 1;
    endcase
    return {hi, r, (r == 0), ov, dz, ill};
  endfunction

  // driver tasks
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int lat;
    logic [EXP_W-1:0] e;
    e = model(op, a, b, lat);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    exp_q.push_back(e);
    lat_q.push_back(cyc + lat);
    bus.start = 1'b0;
    bus.op = 4'($urandom); bus.a = $urandom; bus.b = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("busy_timeout", bus.busy, 1'b0);
  endtask

  task automatic poke_while_busy();
    repeat (3) begin
      @(negedge clk);
      bus.start = 1'b1; bus.op = 4'd2; bus.a = $urandom; bus.b = $urandom;
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h7FFFFFFF;
      3: return 32'h80000000;
      4: return 32'hFFFFFFFF;
      5: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      mon_act = {bus.saida_hi, bus.saida, bus.zero, bus.overflow, bus.div_zero, bus.illegal};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=%0h required=none", mon_act);
      end else begin
        check("result", mon_act, exp_q.pop_front());
        check("latency", cyc, lat_q.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", bus.busy, 1'b0);
    check("reset_done", bus.done, 1'b0);
    check("reset_saida", bus.saida, 32'h0);
    check("reset_saida_hi", bus.saida_hi, 32'h0);
    check("reset_zero", bus.zero, 1'b1);
    check("reset_flags", {bus.overflow, bus.div_zero, bus.illegal}, 3'b000);
    check("reset_state", state_dbg, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // directed corners
    issue(4'd2, 32'h7FFFFFFF, 32'h1);
    issue(4'd7, 32'h80000000, 32'h1);
    issue(4'd6, 32'h80000000, 32'h1);
    issue(4'd3, 32'h5, 32'h5);
    issue(4'd10, 32'h80000000, 32'h4);
    issue(4'd9, 32'h80000000, 32'h4);
    issue(4'd15, 32'h1234, 32'h5678);
    issue(4'd11, 32'hFFFF, 32'h1);
    issue(4'd3, 32'h80000000, 32'h1);
    issue(4'd8, 32'h1, 32'd31);

    issue(4'd12, 32'hFFFFFFFF, 32'h2);
    check("mul_busy", bus.busy, MULDIV_EN);
    if (MULDIV_EN) poke_while_busy();
    wait_idle();
    issue(4'd13, 32'd100, 32'd7);
    wait_idle();
    issue(4'd13, 32'd9, 32'd0);
    check("div0_busy", bus.busy, 1'b0);
    wait_idle();

    // randomised mix
    for (int i = 0; i < 60; i++) begin
      issue(4'($urandom_range(0, 15)), pick_operand(), pick_operand());
      wait_idle();
    end

    // reset in the middle of a multiply
    issue(4'd12, $urandom, $urandom);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", bus.busy, 1'b0);
    check("rst_mid_saida", bus.saida, 32'h0);
    check("rst_mid_done", bus.done, 1'b0);
    check("rst_mid_zero", bus.zero, 1'b1);
    exp_q.delete();
    lat_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(4'd2, 32'd2, 32'd3);
    wait_idle();
    repeat (4) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
